// File: rtl/regfile_multiport_sb_if.sv
// Bus bundle for regfile_multiport_sb: write ports, allocation, read ports and scoreboard.
// The master side is writeback/rename/issue; the slave side is the register file.
interface regfile_multiport_sb_if #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic                    alloc_en;
    logic [AW-1:0]           alloc_addr;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_ready;
    logic [DEPTH-1:0]        busy;

    modport master (
        output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
        input  rd_data, rd_ready, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
        output rd_data, rd_ready, busy
    );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Multi-port register file with hardwired zero register, optional write-to-read
// bypass and a per-entry busy scoreboard for operand readiness.
module regfile_multiport_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_multiport_sb_if.slave rf
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned ZERO_U  = ZERO_REG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW-1:0]    wa, ra, ba;

    // Real registers exclude the zero register and any address past DEPTH.
    function automatic logic is_real(input logic [AW-1:0] a);
        return (32'(a) < DEPTH_U) && (32'(a) != ZERO_U);
    endfunction

    // Ascending port order makes the highest-index enabled port win on collisions;
    // allocation is applied last so a same-cycle alloc supersedes the write's clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        wa     = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wa = rf.wr_addr[p*AW +: AW];
            if (rf.wr_en[p] && is_real(wa)) begin
                mem_d[wa]  = rf.wr_data[p*WIDTH +: WIDTH];
                busy_d[wa] = 1'b0;
            end
        end
        if (rf.alloc_en && is_real(rf.alloc_addr)) begin
            busy_d[rf.alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Reads are forced to zero/ready while reset is high so same-cycle writes
    // cannot leak through the bypass path.
    always_comb begin
        rf.rd_data  = '0;
        rf.rd_ready = '1;
        ra          = '0;
        ba          = '0;
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_RD; r++) begin
                ra = rf.rd_addr[r*AW +: AW];
                if (is_real(ra)) begin
                    rf.rd_data[r*WIDTH +: WIDTH] = mem_q[ra];
                    rf.rd_ready[r]               = ~busy_q[ra];
                    if (BYPASS != 0) begin
                        for (int unsigned p = 0; p < NUM_WR; p++) begin
                            ba = rf.wr_addr[p*AW +: AW];
                            if (rf.wr_en[p] && (ba == ra)) begin
                                rf.rd_data[r*WIDTH +: WIDTH] = rf.wr_data[p*WIDTH +: WIDTH];
                                rf.rd_ready[r]               = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign rf.busy = busy_q;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb: default build, a no-bypass build
// and a 64x32 single-write-port build with register 0 as the zero register.
module tb_regfile_multiport_sb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_multiport_sb_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) d_if ();
    regfile_multiport_sb_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) n_if ();
    regfile_multiport_sb_if #(.WIDTH(32), .DEPTH(64), .NUM_RD(4), .NUM_WR(1)) w_if ();

    regfile_multiport_sb #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
                           .ZERO_REG(31), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rf(d_if));
    regfile_multiport_sb #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
                           .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rf(n_if));
    regfile_multiport_sb #(.WIDTH(32), .DEPTH(64), .NUM_RD(4), .NUM_WR(1),
                           .ZERO_REG(0), .BYPASS(1)) dut_w (
        .clk(clk), .reset(reset), .rf(w_if));

    localparam int unsigned D_DAT = 0, D_RDY = 1, D_BSY = 2;
    localparam int unsigned N_DAT = 3, N_RDY = 4, N_BSY = 5;
    localparam int unsigned W_DAT = 6, W_RDY = 7, W_BSY = 8;

    typedef struct {
        string       name;
        int unsigned src;
        int unsigned port;
        logic [63:0] exp;
    } chk_t;

    chk_t sb[$];
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [63:0] e0;
        logic        y0;
        logic [63:0] e1;
        logic        y1;
        logic [31:0] eb;
    } vec_t;

    vec_t vt[17];

    function automatic logic [63:0] actual(input int unsigned src, input int unsigned port);
        case (src)
            D_DAT:   return d_if.rd_data[port*64 +: 64];
            D_RDY:   return {63'b0, d_if.rd_ready[port]};
            D_BSY:   return {32'b0, d_if.busy};
            N_DAT:   return n_if.rd_data[port*64 +: 64];
            N_RDY:   return {63'b0, n_if.rd_ready[port]};
            N_BSY:   return {32'b0, n_if.busy};
            W_DAT:   return {32'b0, w_if.rd_data[port*32 +: 32]};
            W_RDY:   return {63'b0, w_if.rd_ready[port]};
            W_BSY:   return w_if.busy;
            default: return 'x;
        endcase
    endfunction

    task automatic expect_chk(input string name, input int unsigned src,
                              input int unsigned port, input logic [63:0] v);
        sb.push_back('{name, src, port, v});
    endtask

    task automatic check_now();
        chk_t        c;
        logic [63:0] a;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            a = actual(c.src, c.port);
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", c.name, a, c.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        d_if.wr_en = '0; d_if.wr_addr = '0; d_if.wr_data = '0;
        d_if.alloc_en = 1'b0; d_if.alloc_addr = '0; d_if.rd_addr = '0;
        n_if.wr_en = '0; n_if.wr_addr = '0; n_if.wr_data = '0;
        n_if.alloc_en = 1'b0; n_if.alloc_addr = '0; n_if.rd_addr = '0;
        w_if.wr_en = '0; w_if.wr_addr = '0; w_if.wr_data = '0;
        w_if.alloc_en = 1'b0; w_if.alloc_addr = '0; w_if.rd_addr = '0;
    endtask

    initial begin
        //       we     a0  d0         a1  d1           ae aa  r0  r1  e0         y0 e1        y1 eb
        vt[0]  = '{2'b00, 0,  0,         0,  0,           0, 0,  0,  5,  0,         1, 0,        1, 0};
        vt[1]  = '{2'b11, 3,  64'h1F,    31, 64'hFFFF,    0, 0,  3,  31, 64'h1F,    1, 0,        1, 0};
        vt[2]  = '{2'b00, 0,  0,         0,  0,           0, 0,  3,  31, 64'h1F,    1, 0,        1, 0};
        vt[3]  = '{2'b11, 7,  64'hAA,    7,  64'hBB,      0, 0,  7,  3,  64'hBB,    1, 64'h1F,   1, 0};
        vt[4]  = '{2'b00, 0,  0,         0,  0,           0, 0,  7,  7,  64'hBB,    1, 64'hBB,   1, 0};
        vt[5]  = '{2'b00, 0,  0,         0,  0,           1, 9,  9,  3,  0,         1, 64'h1F,   1, 0};
        vt[6]  = '{2'b00, 0,  0,         0,  0,           0, 0,  9,  3,  0,         0, 64'h1F,   1, 32'h200};
        vt[7]  = '{2'b00, 0,  0,         0,  0,           0, 0,  9,  3,  0,         0, 64'h1F,   1, 32'h200};
        vt[8]  = '{2'b01, 9,  64'h42,    0,  0,           0, 0,  9,  3,  64'h42,    1, 64'h1F,   1, 32'h200};
        vt[9]  = '{2'b00, 0,  0,         0,  0,           0, 0,  9,  9,  64'h42,    1, 64'h42,   1, 0};
        vt[10] = '{2'b10, 0,  0,         12, 64'h5,       1, 12, 12, 9,  64'h5,     1, 64'h42,   1, 0};
        vt[11] = '{2'b00, 0,  0,         0,  0,           1, 31, 12, 31, 64'h5,     0, 0,        1, 32'h1000};
        vt[12] = '{2'b00, 0,  0,         0,  0,           0, 0,  31, 12, 0,         1, 64'h5,    0, 32'h1000};
        vt[13] = '{2'b10, 0,  0,         12, 64'h77,      0, 0,  12, 12, 64'h77,    1, 64'h77,   1, 32'h1000};
        vt[14] = '{2'b00, 0,  0,         0,  0,           0, 0,  12, 12, 64'h77,    1, 64'h77,   1, 0};
        vt[15] = '{2'b01, 20, 64'h2020,  20, 64'hBAD,     0, 0,  20, 12, 64'h2020,  1, 64'h77,   1, 0};
        vt[16] = '{2'b00, 0,  0,         0,  0,           0, 0,  20, 21, 64'h2020,  1, 0,        1, 0};

        idle_all();
        repeat (2) @(posedge clk);
        #1;

        // Reset held: a write with matching read must neither forward nor store.
        d_if.wr_en = 2'b01; d_if.wr_addr = {5'd0, 5'd5}; d_if.wr_data = {64'h0, 64'hDEAD};
        d_if.alloc_en = 1'b1; d_if.alloc_addr = 5'd5; d_if.rd_addr = {5'd6, 5'd5};
        expect_chk("rst_rd0", D_DAT, 0, 64'h0);
        expect_chk("rst_rdy", D_RDY, 0, 64'h1);
        expect_chk("rst_busy", D_BSY, 0, 64'h0);
        tick();
        reset = 1'b0;
        idle_all();

        for (int unsigned a = 0; a < 32; a += 2) begin
            d_if.rd_addr = {5'(a + 1), 5'(a)};
            expect_chk($sformatf("init_d%0d", a), D_DAT, 0, 64'h0);
            expect_chk($sformatf("init_d%0d", a + 1), D_DAT, 1, 64'h0);
            expect_chk($sformatf("init_y%0d", a), D_RDY, 0, 64'h1);
            expect_chk($sformatf("init_y%0d", a + 1), D_RDY, 1, 64'h1);
            expect_chk($sformatf("init_b%0d", a), D_BSY, 0, 64'h0);
            tick();
        end

        for (int i = 0; i < 17; i++) begin
            d_if.wr_en      = vt[i].we;
            d_if.wr_addr    = {vt[i].a1, vt[i].a0};
            d_if.wr_data    = {vt[i].d1, vt[i].d0};
            d_if.alloc_en   = vt[i].ae;
            d_if.alloc_addr = vt[i].aa;
            d_if.rd_addr    = {vt[i].r1, vt[i].r0};
            expect_chk($sformatf("v%0d_d0", i), D_DAT, 0, vt[i].e0);
            expect_chk($sformatf("v%0d_y0", i), D_RDY, 0, {63'b0, vt[i].y0});
            expect_chk($sformatf("v%0d_d1", i), D_DAT, 1, vt[i].e1);
            expect_chk($sformatf("v%0d_y1", i), D_RDY, 1, {63'b0, vt[i].y1});
            expect_chk($sformatf("v%0d_busy", i), D_BSY, 0, {32'b0, vt[i].eb});
            tick();
        end
        idle_all();

        // Fill every register with 0x100+i, two per cycle, then read all back.
        for (int unsigned a = 0; a < 32; a += 2) begin
            d_if.wr_en   = 2'b11;
            d_if.wr_addr = {5'(a + 1), 5'(a)};
            d_if.wr_data = {64'h100 + 64'(a + 1), 64'h100 + 64'(a)};
            tick();
        end
        idle_all();
        for (int unsigned a = 0; a < 32; a += 2) begin
            d_if.rd_addr = {5'(a + 1), 5'(a)};
            expect_chk($sformatf("fill_d%0d", a), D_DAT, 0, 64'h100 + 64'(a));
            expect_chk($sformatf("fill_d%0d", a + 1), D_DAT, 1,
                       (a + 1 == 31) ? 64'h0 : 64'h100 + 64'(a + 1));
            tick();
        end

        // Mid-run reset: state must clear before any clock edge.
        d_if.wr_en = 2'b01; d_if.wr_addr = {5'd0, 5'd5}; d_if.wr_data = {64'h0, 64'hDEAD};
        d_if.alloc_en = 1'b1; d_if.alloc_addr = 5'd6;
        tick();
        idle_all();
        d_if.rd_addr = {5'd6, 5'd5};
        expect_chk("pre_rst_d5", D_DAT, 0, 64'hDEAD);
        expect_chk("pre_rst_busy", D_BSY, 0, 64'h40);
        expect_chk("pre_rst_y6", D_RDY, 1, 64'h0);
        @(negedge clk);
        check_now();
        #2;
        reset = 1'b1;
        #1;
        expect_chk("async_rst_d5", D_DAT, 0, 64'h0);
        expect_chk("async_rst_y6", D_RDY, 1, 64'h1);
        expect_chk("async_rst_busy", D_BSY, 0, 64'h0);
        check_now();
        @(posedge clk);
        #1;
        d_if.wr_en = 2'b10; d_if.wr_addr = {5'd5, 5'd0}; d_if.wr_data = {64'h55, 64'h0};
        d_if.alloc_en = 1'b1; d_if.alloc_addr = 5'd6;
        expect_chk("in_rst_d5", D_DAT, 0, 64'h0);
        expect_chk("in_rst_busy", D_BSY, 0, 64'h0);
        tick();
        reset = 1'b0;
        d_if.wr_en = 2'b01; d_if.wr_addr = {5'd0, 5'd8}; d_if.wr_data = {64'h0, 64'h88};
        d_if.alloc_en = 1'b0;
        expect_chk("post_rst_d5", D_DAT, 0, 64'h0);
        expect_chk("post_rst_y6", D_RDY, 1, 64'h1);
        expect_chk("post_rst_busy", D_BSY, 0, 64'h0);
        tick();
        idle_all();
        d_if.rd_addr = {5'd8, 5'd8};
        expect_chk("first_edge_d8", D_DAT, 1, 64'h88);
        tick();

        // No-bypass build: same-cycle reads see stored data and stored busy.
        n_if.wr_en = 2'b01; n_if.wr_addr = {5'd0, 5'd7}; n_if.wr_data = {64'h0, 64'h11};
        tick();
        n_if.wr_en = 2'b11; n_if.wr_addr = {5'd7, 5'd7}; n_if.wr_data = {64'hBB, 64'hAA};
        n_if.rd_addr = {5'd0, 5'd7};
        expect_chk("nb_coll_same", N_DAT, 0, 64'h11);
        expect_chk("nb_coll_rdy", N_RDY, 0, 64'h1);
        tick();
        n_if.wr_en = 2'b00; n_if.alloc_en = 1'b1; n_if.alloc_addr = 5'd9;
        expect_chk("nb_coll_next", N_DAT, 0, 64'hBB);
        tick();
        n_if.alloc_en = 1'b0;
        n_if.wr_en = 2'b01; n_if.wr_addr = {5'd0, 5'd9}; n_if.wr_data = {64'h0, 64'h42};
        n_if.rd_addr = {5'd0, 5'd9};
        expect_chk("nb_wr_same_d", N_DAT, 0, 64'h0);
        expect_chk("nb_wr_same_y", N_RDY, 0, 64'h0);
        expect_chk("nb_wr_busy", N_BSY, 0, 64'h200);
        tick();
        n_if.wr_en = 2'b00;
        expect_chk("nb_wr_next_d", N_DAT, 0, 64'h42);
        expect_chk("nb_wr_next_y", N_RDY, 0, 64'h1);
        expect_chk("nb_wr_next_busy", N_BSY, 0, 64'h0);
        tick();
        idle_all();

        // Wide build: DEPTH=64, WIDTH=32, 4 readers, 1 writer, zero register 0.
        w_if.wr_en = 1'b1; w_if.wr_addr = 6'd63; w_if.wr_data = 32'hCAFE;
        w_if.rd_addr = {6'd0, 6'd0, 6'd0, 6'd63};
        expect_chk("w_byp63", W_DAT, 0, 64'hCAFE);
        expect_chk("w_byp63_y", W_RDY, 0, 64'h1);
        tick();
        w_if.wr_addr = 6'd0; w_if.wr_data = 32'hFFFF;
        w_if.rd_addr = {6'd63, 6'd0, 6'd0, 6'd0};
        expect_chk("w_rd63", W_DAT, 3, 64'hCAFE);
        expect_chk("w_zero_byp", W_DAT, 0, 64'h0);
        tick();
        w_if.wr_en = 1'b0; w_if.alloc_en = 1'b1; w_if.alloc_addr = 6'd40;
        expect_chk("w_zero", W_DAT, 0, 64'h0);
        expect_chk("w_zero_y", W_RDY, 0, 64'h1);
        tick();
        w_if.alloc_en = 1'b0;
        w_if.wr_en = 1'b1; w_if.wr_addr = 6'd40; w_if.wr_data = 32'h42;
        w_if.rd_addr = {6'd0, 6'd40, 6'd0, 6'd0};
        expect_chk("w_byp40", W_DAT, 2, 64'h42);
        expect_chk("w_byp40_y", W_RDY, 2, 64'h1);
        expect_chk("w_busy40", W_BSY, 0, 64'h1 << 40);
        tick();
        w_if.wr_addr = 6'd50; w_if.wr_data = 32'h5;
        w_if.alloc_en = 1'b1; w_if.alloc_addr = 6'd50;
        w_if.rd_addr = {6'd0, 6'd0, 6'd40, 6'd0};
        expect_chk("w_busy_clr", W_BSY, 0, 64'h0);
        expect_chk("w_rd40", W_DAT, 1, 64'h42);
        tick();
        w_if.wr_en = 1'b0; w_if.alloc_addr = 6'd0;
        w_if.rd_addr = {6'd0, 6'd0, 6'd50, 6'd0};
        expect_chk("w_race_d", W_DAT, 1, 64'h5);
        expect_chk("w_race_y", W_RDY, 1, 64'h0);
        expect_chk("w_race_busy", W_BSY, 0, 64'h1 << 50);
        tick();
        w_if.alloc_en = 1'b0;
        expect_chk("w_alloc0_busy", W_BSY, 0, 64'h1 << 50);
        expect_chk("w_alloc0_y", W_RDY, 0, 64'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_multiport_sb.md
Name: regfile_multiport_sb

Overview:
- Parametrised architectural/physical register file: DEPTH entries of WIDTH bits, with NUM_WR write ports and NUM_RD read ports.
- Includes a hardwired zero register, optional same-cycle write-to-read bypass, and a per-entry busy scoreboard used by issue logic to decide operand readiness.
- Sits between decode/rename (allocation) and writeback (write ports); the issue/operand-fetch stage reads it.

Parameters:
- WIDTH, 64, data bits per register.
- DEPTH, 32, number of registers; AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 31, index of the register that always reads 0.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = no forwarding.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses, port p at [p*AW +: AW]
- wr_data  in  NUM_WR*WIDTH  write data, port p at [p*WIDTH +: WIDTH]
- alloc_en  in  1  mark alloc_addr busy (new in-flight producer)
- alloc_addr  in  AW  register being allocated
- rd_addr  in  NUM_RD*AW  read addresses
- rd_data  out  NUM_RD*WIDTH  read data, combinational
- rd_ready  out  NUM_RD  1 = rd_data is valid (not waiting on a producer)
- busy  out  DEPTH  scoreboard vector, bit i = register i in flight

Behaviour:
- Reset (async, active-high): all registers clear to 0 and all busy bits clear to 0 immediately. While reset is high:
  - rd_data = 0;
  - rd_ready = all 1s;
  - busy = 0;
  - all writes and allocations are ignored.
- Writes:
  - Take effect on the rising clk edge when wr_en[p]=1; the value is visible to non-bypassed reads the cycle after the edge.
  - Multi-port collision (two or more enabled ports with the same address): the highest-index port wins for data.
  - Writes to ZERO_REG are ignored.
  - Writes to an address >= DEPTH are ignored.
- Reads:
  - Combinational, zero latency.
  - rd_addr == ZERO_REG -> rd_data = 0, rd_ready = 1.
  - rd_addr >= DEPTH -> rd_data = 0, rd_ready = 1.
  - BYPASS=1 and a same-cycle enabled write matches rd_addr (not ZERO_REG) -> rd_data = that wr_data (highest matching port), rd_ready = 1.
  - Otherwise rd_data = stored value and rd_ready = ~busy[rd_addr].
  - BYPASS=0 -> stored value only, and rd_ready ignores same-cycle writes.
- Scoreboard (per entry, updated at the rising edge):
  - alloc_en and alloc_addr == i -> busy[i] <= 1.
  - Else any enabled write to i -> busy[i] <= 0.
  - Else busy[i] holds.
  - Alloc and write to the same entry in the same cycle: alloc wins and busy stays/becomes 1 (the newer producer supersedes). The write data is still stored.
  - Alloc of ZERO_REG or an out-of-range address is ignored; busy[ZERO_REG] is constant 0.
- Reset asserted mid-operation: state clears asynchronously. The first edge after deassertion processes inputs normally. No pending writes or allocations survive reset.
- No internal handshake/backpressure: the producer is responsible for not allocating a register that issue logic still needs in its old version.

Test Plan:
- Reset then read: assert reset, then deassert; read all 32 addresses -> rd_data = 0, rd_ready = 1, busy = 0. Assert reset mid-run after writing reg 5 = 64'hDEAD -> reg 5 reads 0 immediately, before any clock edge.
- Write/read and zero register: write reg 3 = 64'h1F via port 0, and write reg 31 = 64'hFFFF via port 1. Next cycle: reg 3 reads 64'h1F, reg 31 reads 0. Write-then-read all 31 non-zero registers with distinct values (64'h100+i) -> each returns its own value.
- Write collision and bypass: ports 0 and 1 both write reg 7 (64'hAA, 64'hBB) while rd_addr[0]=7.
  - BYPASS=1: same-cycle rd_data = 64'hBB, rd_ready = 1; stored value 64'hBB afterwards.
  - BYPASS=0 build: same cycle returns the old value; next cycle returns 64'hBB.
- Scoreboard lifecycle: alloc reg 9 -> next cycle busy[9] = 1 and rd_ready = 0 for reads of 9. Write reg 9 = 64'h42 two cycles later -> same-cycle rd_ready = 1 (bypass); following cycle busy[9] = 0.
- Alloc/write race: in one cycle alloc reg 12 and write reg 12 = 64'h5 -> next cycle busy[12] = 1 and stored value = 64'h5. Alloc reg 31 -> busy[31] stays 0.
- Parameter sweep: instantiate with WIDTH=32, DEPTH=64, NUM_RD=4, NUM_WR=1, ZERO_REG=0. Repeat the previous scenarios with scaled addresses. Also write/read address 63 (valid) and confirm reg 0 reads 0.
